// File: rtl/irq_controller_pkg.sv
// Shared types and constants for the interrupt controller: FSM states, register map, defaults.
// Source ids are 3 bits wide (STATUS exposes active_id[2:0]), so NUM_SRC is at most 8.
package irq_ctrl_pkg;

  localparam int          NUM_SRC_DEF   = 4;
  localparam int          VEC_SHIFT_DEF = 4;
  localparam logic [31:0] BASE_RST_DEF  = 32'h0000_0180;
  localparam int          ID_W          = 3;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_BASE    = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/irq_controller_rr_arbiter.sv
// Round-robin pick over the eligible vector, starting one past last_id; purely combinational.
// No backpressure: grant is re-evaluated every cycle and only sampled by the controller in IDLE.
module rr_arbiter
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic [NUM_SRC-1:0] elig,
  input  logic [ID_W-1:0]    last_id,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld
);

  int idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_id) + k) % NUM_SRC;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: eligible source in IDLE -> irq the next cycle, held until iack.
// No backpressure; after iack irq stays low for one GAP plus one IDLE cycle before the next dispatch.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_SRC   = NUM_SRC_DEF,
  parameter int          VEC_SHIFT = VEC_SHIFT_DEF,
  parameter logic [31:0] BASE_RST  = BASE_RST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               iack,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [31:0]        wd,
  output logic [31:0]        rd,
  output logic               irq,
  output logic [31:0]        EAddr
);

  state_t             state;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [31:2]        base;
  logic [ID_W-1:0]    active_id;
  logic [ID_W-1:0]    last_id;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] svc_clr;
  logic [NUM_SRC-1:0] elig;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;

  assign rise    = src & ~src_q;
  assign w1c     = (we && addr == REG_PENDING) ? wd[NUM_SRC-1:0] : '0;
  assign svc_clr = (state == ACTIVE && iack) ? (NUM_SRC'(1) << active_id) : '0;
  assign elig    = pending & enable;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .elig    (elig),
    .last_id (last_id),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src_q     <= '0;
      pending   <= '0;
      enable    <= '0;
      base      <= BASE_RST[31:2];
      active_id <= '0;
      last_id   <= ID_W'(NUM_SRC - 1);
      irq       <= 1'b0;
    end else begin
      src_q <= src;
      // Clears are applied first so a same-cycle rising edge always re-arms the bit.
      pending <= (pending & ~(w1c | svc_clr)) | rise;
      if (we && addr == REG_ENABLE) enable <= wd[NUM_SRC-1:0];
      if (we && addr == REG_BASE)   base   <= wd[31:2];
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            active_id <= gnt_id;
            state     <= ACTIVE;
            irq       <= 1'b1;
          end
        end
        ACTIVE: begin
          if (iack) begin
            last_id <= active_id;
            state   <= GAP;
            irq     <= 1'b0;
          end
        end
        GAP:     state <= IDLE;
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  assign EAddr = irq ? ({base, 2'b00} + (32'(active_id) << VEC_SHIFT)) : 32'h0;

  always_comb begin
    rd = '0;
    case (addr)
      REG_ENABLE:  rd[NUM_SRC-1:0] = enable;
      REG_BASE:    rd              = {base, 2'b00};
      REG_PENDING: rd[NUM_SRC-1:0] = pending;
      REG_STATUS:  rd[5:0]         = {state, 1'b0, active_id};
      default:     rd              = '0;
    endcase
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_SRC, default 4, number of interrupt sources.
REQ-002 Parameter VEC_SHIFT, default 4, log2 of vector stride in bytes.
REQ-003 Parameter BASE_RST, default 32'h0000_0180, reset value of vector base.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 src  input  NUM_SRC  interrupt sources, synchronous to clk, active-high.
REQ-007 iack  input  1  one-cycle pulse from core at return-from-exception, ending the current service.
REQ-008 we  input  1  config register write strobe.
REQ-009 addr  input  2  config register select.
REQ-010 wd  input  32  config write data.
REQ-011 rd  output  32  config read data, combinational from addr.
REQ-012 irq  output  1  interrupt request to core.
REQ-013 EAddr  output  32  handler address for the active source.

Function
REQ-014 Rising-edge detect per source: prev-sample register; an edge sets pending[i].
REQ-015 Registers: addr 0 ENABLE[NUM_SRC-1:0] (RW); addr 1 BASE[31:2] (RW, bits 1:0 read 0); addr 2 PENDING (read; write-1-to-clear); addr 3 STATUS = {26'b0, state[1:0], 1'b0, active_id[2:0]} (RO); unused bits read 0.
REQ-016 Same-cycle edge set and W1C clear on one bit: set wins.
REQ-017 Eligible = pending & ENABLE; masked pending bits are retained, never dispatched.
REQ-018 Round-robin selection: search starts at last_id+1, wrapping modulo NUM_SRC; first eligible wins.
REQ-019 FSM states IDLE, ACTIVE, GAP.
REQ-020 IDLE: if any eligible, latch winner into active_id, next = ACTIVE; else stay.
REQ-021 ACTIVE: irq = 1; EAddr = BASE + (active_id << VEC_SHIFT); arbitration frozen; new edges still set pending.
REQ-022 ACTIVE with iack = 1: clear pending[active_id], last_id <= active_id, next = GAP.
REQ-023 Same-cycle new edge on active_id and iack: the edge re-sets pending[active_id] (set wins).
REQ-024 GAP: irq = 0 for exactly one cycle, then IDLE; iack in GAP or IDLE is ignored.
REQ-025 Dispatch latency: eligible in cycle N (IDLE) -> irq = 1 from cycle N+1.
REQ-026 Minimum spacing between consecutive services: irq low for 2 cycles (GAP plus IDLE).
REQ-027 If software clears ENABLE or PENDING for active_id during ACTIVE, the service continues until iack.
REQ-028 irq = 0 and EAddr = 0 in IDLE and GAP.

Reset
REQ-029 On rst: state IDLE, pending 0, ENABLE 0, BASE = BASE_RST, prev samples 0, active_id 0, last_id = NUM_SRC-1 (source 0 wins first).
REQ-030 Outputs under reset: irq 0, EAddr 0; rd reflects reset register values.
REQ-031 Reset asserted mid-ACTIVE: irq drops asynchronously; no pending state survives.

Structure
REQ-032 Package irq_ctrl_pkg holds the state enum, register offsets (ENABLE, BASE, PENDING, STATUS) and default parameter constants.
REQ-033 One sub-module rr_arbiter (combinational: eligible vector plus last_id -> grant id and valid); FSM and registers stay in irq_controller.

Verification
REQ-034 Reset, write ENABLE=4'hF, pulse src[2] -> irq=1 two cycles after the edge, EAddr=32'h0000_01A0, STATUS active_id=2.
REQ-035 Simultaneous edges on src[0] and src[3], ENABLE=4'hF -> serviced 0 then 3; iack after the first gives exactly one irq-low GAP cycle plus the IDLE cycle before the second.
REQ-036 ENABLE=4'h1, edge on src[1] -> no irq, PENDING=4'h2; write ENABLE=4'h3 -> irq with EAddr = BASE+16.
REQ-037 BASE write 32'h8000_0003 -> reads 32'h8000_0000; src[1] vectors to 32'h8000_0010.
REQ-038 During ACTIVE on src[1], a new src[1] edge coincides with iack -> PENDING bit 1 stays set; src[1] is serviced again after GAP.
REQ-039 rst pulsed during ACTIVE -> irq=0 immediately; after release PENDING=0, ENABLE=0, and no irq on later edges until ENABLE is written.
